uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_tx_param.sv | 124 ++++++++++++
 tb/tb_uart_tx_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and serializer state encoding shared by the UART TX blocks
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    // Mode 2'b11 is reserved and behaves like PAR_NONE
    function automatic logic has_parity(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count and registered overflow pulse
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_reset,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             ovf_q, push, pop;

    // A write while full is dropped even if a pop frees a slot in the same cycle
    assign push       = i_wr && !o_full;
    assign pop        = i_rd && !o_empty;
    assign o_full     = level_q == LW'(DEPTH);
    assign o_empty    = level_q == '0;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;
    assign o_data     = mem_q[rd_ptr_q];

    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_q + LW'(push) - LW'(pop);
            ovf_q    <= i_wr && o_full;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART serializer with selectable parity and stop-bit count
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int TICK_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_reset,
    input  logic                        sample_tick,
    input  logic                        i_wr,
    input  logic [DATA_BITS-1:0]        i_data,
    input  logic [1:0]                  i_parity_mode,
    input  logic                        i_stop2,
    output logic                        o_TX,
    output logic                        o_TX_Active,
    output logic                        o_TX_Done,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_overflow
);
    localparam int TW = $clog2(TICK_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS);

    state_e               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] sh_q, head;
    logic                 par_en_q, par_q, stop2_q, stop_cnt_q;
    logic                 tx_q, active_q, done_q;
    logic                 bit_end, frame_end, pop;

    assign bit_end   = sample_tick && tick_q == TW'(TICK_PER_BIT - 1);
    assign frame_end = state_q == STOP && bit_end && stop_cnt_q == stop2_q;
    // Popping on the last stop tick chains frames with no idle bit in between
    assign pop       = !o_empty && (state_q == IDLE || frame_end);

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_Clock    (i_Clock),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .i_rd       (pop),
        .o_data     (head),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    assign o_TX        = tx_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

    always_ff @(posedge i_Clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                state_q  <= START;
                tick_q   <= '0;
                sh_q     <= head;
                par_en_q <= has_parity(i_parity_mode);
                par_q    <= ^head ^ (i_parity_mode == PAR_ODD);
                stop2_q  <= i_stop2;
                tx_q     <= 1'b0;
                active_q <= 1'b1;
                done_q   <= frame_end;
            end else if (state_q != IDLE) begin
                tick_q <= bit_end ? '0 : tick_q + TW'(sample_tick);
                if (bit_end) begin
                    case (state_q)
                        START: begin
                            state_q <= DATA;
                            bit_q   <= '0;
                            tx_q    <= sh_q[0];
                        end
                        DATA: begin
                            if (bit_q == BW'(DATA_BITS - 1)) begin
                                state_q    <= par_en_q ? PARITY : STOP;
                                tx_q       <= par_en_q ? par_q : 1'b1;
                                stop_cnt_q <= 1'b0;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                                sh_q  <= sh_q >> 1;
                                tx_q  <= sh_q[1];
                            end
                        end
                        PARITY: begin
                            state_q    <= STOP;
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
                        end
                        STOP: begin
                            if (stop_cnt_q == stop2_q) begin
                                state_q  <= IDLE;
                                tx_q     <= 1'b1;
                                active_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                stop_cnt_q <= 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized-tick checks of the UART serializer against a per-frame bit model
module tb_uart_tx_param;
    localparam int DB  = 8;
    localparam int TPB = 16;
    localparam int FD  = 4;
    localparam int LW  = $clog2(FD) + 1;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic          i_wr = 1'b0;
    logic [DB-1:0] i_data = '0;
    logic [1:0]    i_parity_mode = 2'b00;
    logic          i_stop2 = 1'b0;
    logic          o_TX, o_TX_Active, o_TX_Done, o_full, o_empty, o_overflow;
    logic [LW-1:0] o_level;

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            obs_n = 0;
    int            exp_n = 0;
    logic [1023:0] obs_v = '0;
    logic [1023:0] exp_v = '0;
    logic          mon_en = 1'b1;

    uart_tx_param #(.DATA_BITS(DB), .TICK_PER_BIT(TPB), .FIFO_DEPTH(FD)) dut (
        .i_Clock       (clk),
        .i_reset       (i_reset),
        .sample_tick   (sample_tick),
        .i_wr          (i_wr),
        .i_data        (i_data),
        .i_parity_mode (i_parity_mode),
        .i_stop2       (i_stop2),
        .o_TX          (o_TX),
        .o_TX_Active   (o_TX_Active),
        .o_TX_Done     (o_TX_Done),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_level       (o_level),
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            sample_tick = ($urandom_range(0, 3) != 0);
        end
    end

    // Line value seen on every ticked cycle of a frame; each bit must fill exactly TPB of them
    always @(negedge clk) begin
        if (o_TX_Done) done_cnt <= done_cnt + 1;
        if (mon_en && o_TX_Active && sample_tick) begin
            obs_v <= {obs_v[1022:0], o_TX};
            obs_n <= obs_n + 1;
        end
    end

    task automatic add_frame(input logic [DB-1:0] d, input logic [1:0] mode, input logic s2, input int lim);
        logic bits[$];
        int   n = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (mode == 2'b01) bits.push_back(^d);
        if (mode == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++)
            for (int t = 0; t < TPB; t++)
                if (n < lim) begin
                    exp_v = {exp_v[1022:0], bits[i]};
                    exp_n++;
                    n++;
                end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_byte(input logic [DB-1:0] d);
        i_wr = 1'b1;
        i_data = d;
        cyc(1);
        i_wr = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 6000) begin
            cyc(1);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout done=%0d need=%0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        cyc(3);
        checks++; if (o_TX !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b want=1", o_TX); end
        checks++; if (o_TX_Active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b want=0", o_TX_Active); end
        checks++; if (o_TX_Done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", o_TX_Done); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", o_overflow); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b want=1", o_empty); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b want=0", o_full); end
        checks++; if (o_level !== '0) begin errors++; $display("FAIL rst_level got=%0d want=0", o_level); end
        i_reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic();
        int b = done_cnt;
        i_parity_mode = 2'b00;
        i_stop2 = 1'b0;
        add_frame(8'h3F, 2'b00, 1'b0, BIG);
        wr_byte(8'h3F);
        checks++; if (o_level !== LW'(1) || o_empty !== 1'b0) begin errors++; $display("FAIL basic_level got=%0d/%b want=1/0", o_level, o_empty); end
        cyc(1);
        checks++; if (o_TX !== 1'b0 || o_TX_Active !== 1'b1 || o_level !== '0) begin errors++; $display("FAIL basic_start tx=%b act=%b lvl=%0d want 0/1/0", o_TX, o_TX_Active, o_level); end
        wait_done(b + 1, "basic");
        cyc(30);
        checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL basic_stream ticks=%0d want=%0d last=%h want=%h", obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
        checks++; if (done_cnt !== b + 1) begin errors++; $display("FAIL basic_done got=%0d want=%0d", done_cnt, b + 1); end
    endtask

    task automatic test_parity_stop();
        logic [1:0] m[3] = '{2'b01, 2'b10, 2'b00};
        logic       s[3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            int b = done_cnt;
            i_parity_mode = m[k];
            i_stop2 = s[k];
            add_frame(8'h3F, m[k], s[k], BIG);
            wr_byte(8'h3F);
            wait_done(b + 1, "cfg");
            cyc(30);
            checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL cfg%0d_stream ticks=%0d want=%0d last=%h want=%h", k, obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
            checks++; if (done_cnt !== b + 1) begin errors++; $display("FAIL cfg%0d_done got=%0d want=%0d", k, done_cnt, b + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] d[4]  = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        logic [LW-1:0] lv[4] = '{LW'(2), LW'(1), LW'(0), LW'(0)};
        int b = done_cnt;
        int seen = 0;
        int gap = 0;
        int n = 0;
        i_parity_mode = 2'b00;
        i_stop2 = 1'b0;
        for (int i = 0; i < 4; i++) add_frame(d[i], 2'b00, 1'b0, BIG);
        for (int i = 0; i < 4; i++) wr_byte(d[i]);
        checks++; if (o_level !== LW'(3)) begin errors++; $display("FAIL b2b_level got=%0d want=3", o_level); end
        while (seen < 4 && n < 6000) begin
            cyc(1);
            n++;
            if (o_TX_Done) begin
                checks++; if (o_level !== lv[seen]) begin errors++; $display("FAIL b2b_level_done%0d got=%0d want=%0d", seen, o_level, lv[seen]); end
                seen++;
            end else if (!o_TX_Active) gap++;
        end
        checks++; if (seen !== 4) begin errors++; $display("FAIL b2b_frames got=%0d want=4", seen); end
        checks++; if (gap !== 0) begin errors++; $display("FAIL b2b_gap idle_cycles=%0d want=0", gap); end
        cyc(30);
        checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL b2b_stream ticks=%0d want=%0d last=%h want=%h", obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
        checks++; if (done_cnt !== b + 4) begin errors++; $display("FAIL b2b_done got=%0d want=%0d", done_cnt, b + 4); end
    endtask

    task automatic test_overflow();
        logic [DB-1:0] d[6];
        logic [1:0]    md = 2'($urandom_range(0, 3));
        logic          s2 = 1'($urandom_range(0, 1));
        int b = done_cnt;
        for (int i = 0; i < 6; i++) d[i] = DB'($urandom);
        i_parity_mode = md;
        i_stop2 = s2;
        for (int i = 0; i < 5; i++) add_frame(d[i], md, s2, BIG);
        wr_byte(d[0]);
        cyc(3);
        for (int i = 1; i < 5; i++) wr_byte(d[i]);
        checks++; if (o_full !== 1'b1 || o_level !== LW'(4)) begin errors++; $display("FAIL ovf_full full=%b lvl=%0d want 1/4", o_full, o_level); end
        wr_byte(d[5]);
        checks++; if (o_overflow !== 1'b1 || o_level !== LW'(4)) begin errors++; $display("FAIL ovf_pulse ovf=%b lvl=%0d want 1/4", o_overflow, o_level); end
        cyc(1);
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_once got=%b want=0", o_overflow); end
        wait_done(b + 5, "ovf");
        cyc(30);
        checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL ovf_stream ticks=%0d want=%0d last=%h want=%h", obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
        checks++; if (done_cnt !== b + 5) begin errors++; $display("FAIL ovf_done got=%0d want=%0d", done_cnt, b + 5); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b want=1", o_empty); end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d1 = DB'($urandom);
        logic [DB-1:0] d2 = DB'($urandom);
        logic [DB-1:0] d3 = DB'($urandom);
        logic [1:0]    md = 2'($urandom_range(0, 3));
        logic          s2 = 1'($urandom_range(0, 1));
        int b = done_cnt;
        int base = obs_n;
        int n = 0;
        int k;
        i_parity_mode = md;
        i_stop2 = s2;
        wr_byte(d1);
        wr_byte(d2);
        // 72 ticks in lands in the middle of data bit 3
        while (obs_n - base < 72 && n < 3000) begin
            cyc(1);
            n++;
        end
        k = obs_n - base;
        checks++; if (o_TX !== d1[3]) begin errors++; $display("FAIL mid_bit3 got=%b want=%b", o_TX, d1[3]); end
        mon_en = 1'b0;
        i_reset = 1'b1;
        add_frame(d1, md, s2, k);
        cyc(1);
        checks++; if (o_TX !== 1'b1 || o_TX_Active !== 1'b0) begin errors++; $display("FAIL mid_abort tx=%b act=%b want 1/0", o_TX, o_TX_Active); end
        checks++; if (o_empty !== 1'b1 || o_level !== '0) begin errors++; $display("FAIL mid_flush empty=%b lvl=%0d want 1/0", o_empty, o_level); end
        i_reset = 1'b0;
        cyc(300);
        checks++; if (done_cnt !== b || o_TX_Active !== 1'b0) begin errors++; $display("FAIL mid_nodone done=%0d act=%b want %0d/0", done_cnt, o_TX_Active, b); end
        mon_en = 1'b1;
        add_frame(d3, md, s2, BIG);
        wr_byte(d3);
        wait_done(b + 1, "mid");
        cyc(30);
        checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL mid_stream ticks=%0d want=%0d last=%h want=%h", obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
        checks++; if (done_cnt !== b + 1) begin errors++; $display("FAIL mid_done got=%0d want=%0d", done_cnt, b + 1); end
    endtask

    task automatic test_cfg_change();
        logic [DB-1:0] x1 = DB'($urandom);
        logic [DB-1:0] x2 = DB'($urandom);
        int b = done_cnt;
        i_parity_mode = 2'b01;
        i_stop2 = 1'b0;
        add_frame(x1, 2'b01, 1'b0, BIG);
        add_frame(x2, 2'b10, 1'b1, BIG);
        wr_byte(x1);
        wr_byte(x2);
        cyc(20);
        i_parity_mode = 2'b10;
        i_stop2 = 1'b1;
        wait_done(b + 2, "chg");
        cyc(30);
        checks++; if (obs_n !== exp_n || obs_v !== exp_v) begin errors++; $display("FAIL chg_stream ticks=%0d want=%0d last=%h want=%h", obs_n, exp_n, obs_v[63:0], exp_v[63:0]); end
        checks++; if (done_cnt !== b + 2) begin errors++; $display("FAIL chg_done got=%0d want=%0d", done_cnt, b + 2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_stop();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_cfg_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
